// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM states and default sizes.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_NUM_REQ = 4;

endpackage

// File: rtl/seq_loadable_counter.sv
// WIDTH-bit up-counter; En gates all activity, Load selects the load value.
module seq_loadable_counter
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic             En,
    input  logic [WIDTH-1:0] Load_Val,
    output logic [WIDTH-1:0] Count
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (En) begin
            Count <= Load ? Load_Val : Count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Round-robin arbiter plus FSM sharing one loadable counter between NUM_REQ
// requesters, each running a start-to-terminal interval.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] Start_Val,
    input  logic [NUM_REQ*WIDTH-1:0] Term_Val,
    input  logic                     Abort,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Done,
    output logic                     Aborted,
    output logic                     Busy,
    output logic [WIDTH-1:0]         Count_Out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    seq_state_t         state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic [WIDTH-1:0]   term_q, term_d;
    logic [WIDTH-1:0]   start_sel, term_sel;
    logic [NUM_REQ-1:0] grant_d, done_d;
    logic               abort_taken;
    logic               cnt_load, cnt_en;
    int unsigned        j;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign start_sel = Start_Val[idx*WIDTH +: WIDTH];
    assign term_sel  = Term_Val[idx*WIDTH +: WIDTH];

    // First set request at or above the pointer, wrapping circularly.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && Req[j]) begin
                found = 1'b1;
                sel   = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        ptr_d       = ptr;
        term_d      = term_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        abort_taken = 1'b0;
        done_d      = '0;
        grant_d     = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    idx_d   = sel;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (Abort) begin
                    abort_taken = 1'b1;
                end else begin
                    cnt_load = 1'b1;
                    cnt_en   = 1'b1;
                    term_d   = term_sel;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (Abort) begin
                    abort_taken = 1'b1;
                end else if (Count_Out == term_q) begin
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = wrap_inc(idx);
            end
            default: state_d = IDLE;
        endcase
        // Abort outranks a terminal match; the counter is left untouched.
        if (abort_taken) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(idx);
        end
        if (state == RUN && state_d == DONE) done_d[idx] = 1'b1;
        if (state_d == LOAD || state_d == RUN) grant_d[idx_d] = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= '0;
            ptr     <= '0;
            term_q  <= '0;
            Grant   <= '0;
            Done    <= '0;
            Aborted <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            ptr     <= ptr_d;
            term_q  <= term_d;
            Grant   <= grant_d;
            Done    <= done_d;
            Aborted <= abort_taken;
            Busy    <= (state_d != IDLE);
        end
    end

    seq_loadable_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (cnt_load),
        .En       (cnt_en),
        .Load_Val (start_sel),
        .Count    (Count_Out)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomised and directed checks of counter_sequencer against a timeline model.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [N-1:0]   Req = '0;
    logic [N*W-1:0] Start_Val = '0;
    logic [N*W-1:0] Term_Val = '0;
    logic           Abort = 1'b0;
    logic [N-1:0]   Grant, Done;
    logic           Aborted, Busy;
    logic [W-1:0]   Count_Out;

    counter_sequencer #(.WIDTH(W), .NUM_REQ(N)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Start_Val(Start_Val),
        .Term_Val(Term_Val), .Abort(Abort), .Grant(Grant), .Done(Done),
        .Aborted(Aborted), .Busy(Busy), .Count_Out(Count_Out)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: a job is a timeline measured in edges since its sample edge.
    bit           m_job;
    int           m_owner, m_k, m_dly, m_ptr;
    logic [W-1:0] m_st, m_tm, m_cnt;
    logic [N-1:0] m_g, m_dn;
    bit           m_ab, m_bz;

    task automatic model_reset();
        m_job = 0; m_owner = 0; m_k = 0; m_dly = 0; m_ptr = 0;
        m_st = '0; m_tm = '0; m_cnt = '0; m_g = '0; m_dn = '0; m_ab = 0; m_bz = 0;
    endtask

    task automatic model_abort();
        m_ab = 1; m_g = '0; m_bz = 0; m_job = 0; m_ptr = (m_owner + 1) % N;
    endtask

    task automatic model_step();
        logic [W-1:0] diff;
        if (!m_job) begin
            m_ab = 0; m_dn = '0;
            if (Req != '0) begin
                for (int o = N - 1; o >= 0; o--)
                    if (Req[(m_ptr + o) % N]) m_owner = (m_ptr + o) % N;
                m_job = 1; m_k = 0; m_bz = 1;
                m_g = '0; m_g[m_owner] = 1'b1;
            end
        end else begin
            m_k++;
            if (m_k == 1) begin
                if (Abort) model_abort();
                else begin
                    m_st = Start_Val[m_owner*W +: W];
                    m_tm = Term_Val[m_owner*W +: W];
                    diff = m_tm - m_st;
                    m_dly = int'(diff);
                    m_cnt = m_st;
                end
            end else if (m_k <= 1 + m_dly) begin
                if (Abort) model_abort();
                else m_cnt = m_cnt + 1'b1;
            end else if (m_k == 2 + m_dly) begin
                if (Abort) model_abort();
                else begin
                    m_dn = '0; m_dn[m_owner] = 1'b1; m_g = '0;
                end
            end else begin
                m_dn = '0; m_bz = 0; m_job = 0; m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic check_model();
        vectors++;
        if (Grant !== m_g || Done !== m_dn || Aborted !== m_ab || Busy !== m_bz ||
            Count_Out !== m_cnt) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t got grant=%b done=%b aborted=%b busy=%b count=%h, want grant=%b done=%b aborted=%b busy=%b count=%h",
                     $time, Grant, Done, Aborted, Busy, Count_Out, m_g, m_dn, m_ab, m_bz, m_cnt);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        if (Reset) model_reset();
        else model_step();
        #1 check_model();
    endtask

    task automatic do_reset();
        Req = '0; Abort = 1'b0; Reset = 1'b1;
        model_reset();
        cycle();
        cycle();
        Reset = 1'b0;
    endtask

    task automatic set_vals(input int i, input logic [W-1:0] s, input logic [W-1:0] t);
        Start_Val[i*W +: W] = s;
        Term_Val[i*W +: W] = t;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic run_job(input int idx, input logic [W-1:0] s, input logic [W-1:0] t, input int d);
        logic [N-1:0] oh;
        oh = '0; oh[idx] = 1'b1;
        Req = oh;
        set_vals(idx, s, t);
        cycle();
        lit("grant_load", 64'(Grant), 64'(oh));
        for (int e = 1; e <= 3 + d; e++) begin
            cycle();
            if (e == 1) lit("count_start", 64'(Count_Out), 64'(s));
            if (e == 1 + d) lit("count_term", 64'(Count_Out), 64'(t));
            if (e == 2 + d) begin
                lit("done_pulse", 64'(Done), 64'(oh));
                lit("grant_off_in_done", 64'(Grant), 64'(0));
                Req = '0;
            end
            if (e == 3 + d) begin
                lit("done_cleared", 64'(Done), 64'(0));
                lit("busy_off", 64'(Busy), 64'(0));
            end
        end
    endtask

    task automatic wait_for(input string name, input logic [W-1:0] cnt, input logic [N-1:0] g);
        int n = 0;
        while (!(Count_Out == cnt && Grant == g) && n < 400) begin
            cycle();
            n++;
        end
        lit(name, 64'(n < 400), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (Busy && n < 50) begin
            cycle();
            n++;
        end
        lit("drain_idle", 64'(Busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int dorder[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        bit prev_g;
        logic [W-1:0] s;

        // Reset state and directed intervals
        do_reset();
        lit("reset_grant", 64'(Grant), 64'(0));
        lit("reset_count", 64'(Count_Out), 64'(0));
        run_job(0, 16'h0010, 16'h0014, 4);
        run_job(2, 16'hFFFE, 16'h0001, 3);
        run_job(1, 16'h1234, 16'h1234, 0);

        // Round robin with all requesters held high
        do_reset();
        for (int i = 0; i < N; i++) set_vals(i, 16'(i * 256), 16'(i * 256 + 2));
        Req = '1;
        prev_g = 0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            cycle();
            if (Grant != '0 && !prev_g) order.push_back(idx_of(Grant));
            prev_g = (Grant != '0);
            if (Done != '0) dorder.push_back(idx_of(Done));
        end
        Req = '0;
        drain();
        lit("rr_grants_seen", 64'(order.size()), 64'(5));
        for (int i = 0; i < 5 && i < order.size(); i++) lit("rr_grant_order", 64'(order[i]), 64'(exp_order[i]));
        lit("rr_dones_seen", 64'(dorder.size() >= 4), 64'(1));
        for (int i = 0; i < 4 && i < dorder.size(); i++) lit("rr_done_order", 64'(dorder[i]), 64'(exp_order[i]));

        // Abort mid-run, then abort coinciding with a terminal match
        do_reset();
        set_vals(1, 16'h0000, 16'h0100);
        set_vals(2, 16'h0050, 16'h0051);
        Req = 4'b0010;
        cycle();
        Req = 4'b0111;
        wait_for("abort_wait", 16'h0005, 4'b0010);
        Abort = 1'b1;
        cycle();
        Abort = 1'b0;
        lit("aborted_pulse", 64'(Aborted), 64'(1));
        lit("abort_no_done", 64'(Done), 64'(0));
        lit("abort_count_hold", 64'(Count_Out), 64'(16'h0005));
        lit("abort_grant_drop", 64'(Grant), 64'(0));
        Req = 4'b0101;
        cycle();
        lit("abort_next_grant", 64'(Grant), 64'(4'b0100));
        lit("aborted_cleared", 64'(Aborted), 64'(0));
        Req = 4'b0000;
        drain();
        set_vals(1, 16'h0000, 16'h0003);
        Req = 4'b0010;
        wait_for("abort_term_wait", 16'h0003, 4'b0010);
        Abort = 1'b1;
        cycle();
        Abort = 1'b0;
        Req = '0;
        lit("abort_term_pulse", 64'(Aborted), 64'(1));
        lit("abort_term_no_done", 64'(Done), 64'(0));
        cycle();
        lit("abort_term_no_late_done", 64'(Done), 64'(0));

        // Reset asserted mid-run
        do_reset();
        run_job(1, 16'h0000, 16'h0001, 1);
        set_vals(2, 16'h0000, 16'h0020);
        Req = 4'b0100;
        wait_for("reset_wait", 16'h0007, 4'b0100);
        Req = 4'b1001;
        #2 Reset = 1'b1;
        #1;
        lit("rst_grant", 64'(Grant), 64'(0));
        lit("rst_done", 64'(Done), 64'(0));
        lit("rst_aborted", 64'(Aborted), 64'(0));
        lit("rst_busy", 64'(Busy), 64'(0));
        lit("rst_count", 64'(Count_Out), 64'(0));
        model_reset();
        cycle();
        Reset = 1'b0;
        cycle();
        lit("rst_first_grant", 64'(Grant), 64'(4'b0001));
        Req = '0;
        drain();

        // Randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!Req[i] && $urandom_range(0, 3) == 0) begin
                    s = W'($urandom);
                    set_vals(i, s, s + W'($urandom_range(0, 12)));
                    Req[i] = 1'b1;
                end
            end
            if (m_job && $urandom_range(0, 3) == 0) Term_Val[m_owner*W +: W] = W'($urandom);
            if (m_job && $urandom_range(0, 19) == 0) Req[m_owner] = 1'b0;
            Abort = ($urandom_range(0, 40) == 0);
            cycle();
            Req = Req & ~Done;
            if (Aborted) Req[m_owner] = 1'b0;
        end
        Abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
